// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a one-byte holding register for gap-free back-to-back frames.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data bits and the stop bit.
module uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 217
) (
  input  logic       i_Clock,
  input  logic       i_Reset,
  input  logic       i_TX_DV,
  input  logic [7:0] i_TX_Byte,
  output logic       o_TX_Ready,
  output logic       o_TX_Active,
  output logic       o_TX_Serial,
  output logic       o_TX_Done
);

  localparam logic [15:0] LAST_CLK = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  state_t      state;
  logic [15:0] clk_cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift_reg;
  logic [7:0]  hold_reg;
`ifdef UART_TX_PARITY_EN
  logic        parity_bit;
`endif
  logic        bit_end;
  logic        load;

  // o_TX_Ready doubles as the "holding register empty" flag.
  always_comb begin
    bit_end = (clk_cnt == LAST_CLK);
    load    = !o_TX_Ready && ((state == S_IDLE) || (state == S_STOP && bit_end));
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state       <= S_IDLE;
      clk_cnt     <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      hold_reg    <= '0;
`ifdef UART_TX_PARITY_EN
      parity_bit  <= 1'b0;
`endif
      o_TX_Ready  <= 1'b1;
      o_TX_Active <= 1'b0;
      o_TX_Serial <= 1'b1;
      o_TX_Done   <= 1'b0;
    end else begin
      o_TX_Done <= 1'b0;

      if (i_TX_DV && o_TX_Ready) begin
        hold_reg   <= i_TX_Byte;
        o_TX_Ready <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          clk_cnt     <= '0;
          o_TX_Serial <= 1'b1;
        end

        S_START: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            bit_idx     <= '0;
            o_TX_Serial <= shift_reg[0];
            state       <= S_DATA;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        S_DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              o_TX_Serial <= parity_bit;
              state       <= S_PARITY;
`else
              o_TX_Serial <= 1'b1;
              state       <= S_STOP;
`endif
            end else begin
              bit_idx     <= bit_idx + 3'd1;
              o_TX_Serial <= shift_reg[bit_idx + 3'd1];
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

`ifdef UART_TX_PARITY_EN
        S_PARITY: begin
          if (bit_end) begin
            clk_cnt     <= '0;
            o_TX_Serial <= 1'b1;
            state       <= S_STOP;
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end
`endif

        S_STOP: begin
          if (bit_end) begin
            clk_cnt   <= '0;
            o_TX_Done <= 1'b1;
            if (o_TX_Ready) begin
              o_TX_Active <= 1'b0;
              state       <= S_IDLE;
            end
          end else begin
            clk_cnt <= clk_cnt + 16'd1;
          end
        end

        default: state <= S_IDLE;
      endcase

      // Frame load overrides the per-state updates, both from IDLE and on the
      // last STOP edge, so a queued byte starts with no idle gap.
      if (load) begin
        shift_reg   <= hold_reg;
`ifdef UART_TX_PARITY_EN
        parity_bit  <= ^hold_reg;
`endif
        o_TX_Ready  <= 1'b1;
        o_TX_Active <= 1'b1;
        o_TX_Serial <= 1'b0;
        clk_cnt     <= '0;
        state       <= S_START;
      end
    end
  end

endmodule
